ste_array_matcher: RTL and testbench
====================================

STE_ARRAY_MATCHER -- requirements
Module: ste_array_matcher

Interface
REQ-001 Parameter NUM_STE, default 8: number of state transition elements (STEs); range 2..16.
REQ-002 Parameter SYMBOL_W, default 16: symbol width (two ASCII bases per symbol); SYMBOL_W >= NUM_STE.
REQ-003 Parameter MATCH_PER_STE, default 4: symbol-table entries per STE; power of two.
REQ-004 clock  in  1  sole clock; all state updates on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cfg_we  in  1  configuration write strobe.
REQ-007 cfg_sel  in  2  write type: 0 set match entry, 1 clear match entry, 2 adjacency row, 3 STE flags.
REQ-008 cfg_ste  in  clog2(NUM_STE)  target STE.
REQ-009 cfg_idx  in  clog2(MATCH_PER_STE)  target match entry.
REQ-010 cfg_data  in  SYMBOL_W  write payload.
REQ-011 start  in  1  begin a stream; sampled only in IDLE.
REQ-012 sym_valid / sym_ready  in / out  1 each  symbol handshake; transfer when both high.
REQ-013 sym_data  in  SYMBOL_W  symbol.
REQ-014 sym_last  in  1  marks final symbol of stream.
REQ-015 busy  out  1  high in RUN.
REQ-016 done  out  1  one-cycle pulse after final symbol processed.
REQ-017 report_valid  out  1  one-cycle pulse: at least one reporting STE matched.
REQ-018 report_vec  out  NUM_STE  reporting STEs that matched; zero when report_valid low.

Function
REQ-019 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on accepted symbol with sym_last; DONE->IDLE unconditionally next cycle.
REQ-020 sym_ready = 1 exactly in RUN; no symbol accepted in IDLE or DONE.
REQ-021 cfg_sel 0: entry[cfg_ste][cfg_idx] := cfg_data, valid := 1; cfg_sel 1: valid := 0.
REQ-022 cfg_sel 2: adjacency row of cfg_ste := cfg_data[NUM_STE-1:0]; bit j set = STE j is a child.
REQ-023 cfg_sel 3: cfg_data[0] start flag, [1] report flag, [2] start mode (0 all-input, 1 start-of-data).
REQ-024 cfg_we honoured only in IDLE; ignored in RUN and DONE; config unchanged by stream end.
REQ-025 Active vector cleared to zero on IDLE->RUN.
REQ-026 Per accepted symbol: enabled_i = active_i OR (start_i AND (mode_i==0 OR first symbol of stream)).
REQ-027 match_i = enabled_i AND sym_data equals any valid entry of STE i; all-invalid STE never matches.
REQ-028 Next active_j = OR over i of (match_i AND adj[i][j]); updated on the accepting edge; unchanged when no transfer.
REQ-029 report_valid/report_vec registered: asserted the cycle after acceptance, report_vec = match AND report flags; report_valid = |report_vec.
REQ-030 Final symbol's report and done pulse occur in the same cycle.
REQ-031 start asserted outside IDLE ignored; start and cfg_we together in IDLE: config write and start both take effect; the write is not visible to the stream.

Reset
REQ-032 reset: FSM IDLE, active, all entry valids, adjacency, flags cleared; busy, done, report_valid, report_vec, report_offset = 0.
REQ-033 reset mid-stream aborts immediately; no done pulse; no report in following cycle.

Configuration
REQ-034 Macro STE_REPORT_OFFSET_EN: defined -> extra output report_offset [31:0], zero-based index of the reported symbol within the stream, wraps at 2^32, valid with report_valid; undefined -> port and counter absent, other behaviour identical.

Verification
REQ-035 Program STE0 {AA,AG,TA,TG} start all-input, STE1 {CC} report, adj 0->1, 1->1; stream AA,AG,CC,CC,AT,CC(last) -> reports at symbols 2,3 (report_vec=0x02), none at 5; done with symbol 5.
REQ-036 Same program, STE0 start-of-data; stream AG,TA,CC(last) -> no report; stream AA,CC -> report at index 1.
REQ-037 Hold sym_valid low 3 cycles mid-stream -> active vector and outputs unchanged, no report pulses.
REQ-038 cfg_we in RUN clearing STE1 entry 0 -> ignored, CC still reports; same write in IDLE -> next stream no reports.
REQ-039 reset asserted after 2nd symbol of 6 -> busy=0, no done, next stream behaves as fresh.
REQ-040 With STE_REPORT_OFFSET_EN, REQ-035 stream -> report_offset 2 then 3.

Source files
------------

// File: rtl/ste_array_matcher.sv
// Array of state transition elements that matches a symbol stream against per-STE symbol sets.
// Optional macro STE_REPORT_OFFSET_EN adds report_offset (stream index of each reported symbol).
module ste_array_matcher #(
  parameter int NUM_STE       = 8,
  parameter int SYMBOL_W      = 16,
  parameter int MATCH_PER_STE = 4,
  localparam int SW = (NUM_STE > 1) ? $clog2(NUM_STE) : 1,
  localparam int MW = (MATCH_PER_STE > 1) ? $clog2(MATCH_PER_STE) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [SW-1:0]       cfg_ste,
  input  logic [MW-1:0]       cfg_idx,
  input  logic [SYMBOL_W-1:0] cfg_data,
  input  logic                start,
  input  logic                sym_valid,
  output logic                sym_ready,
  input  logic [SYMBOL_W-1:0] sym_data,
  input  logic                sym_last,
  output logic                busy,
  output logic                done,
  output logic                report_valid,
  output logic [NUM_STE-1:0]  report_vec,
`ifdef STE_REPORT_OFFSET_EN
  output logic [31:0]         report_offset,
`endif
  output logic [1:0]          dbg_state
);

  // Symbol handshake: a symbol transfers on a rising edge where sym_valid and
  // sym_ready are both high; sym_ready is high exactly in S_RUN.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic [SYMBOL_W-1:0]      r_entry   [NUM_STE][MATCH_PER_STE];
  logic [MATCH_PER_STE-1:0] r_entry_v [NUM_STE];
  logic [NUM_STE-1:0]       r_adj     [NUM_STE];
  logic [NUM_STE-1:0]       r_start_f, r_report_f, r_mode_f;
  logic [NUM_STE-1:0]       r_active, r_report_vec;
  logic                     r_report_valid, r_first;

  // A write issued together with start is held until the stream ends so the
  // running stream sees the old configuration.
  logic                r_pend_v;
  logic [1:0]          r_pend_sel;
  logic [SW-1:0]       r_pend_ste;
  logic [MW-1:0]       r_pend_idx;
  logic [SYMBOL_W-1:0] r_pend_data;

  logic                w_xfer, w_launch, w_wr_en;
  logic [1:0]          w_wr_sel;
  logic [SW-1:0]       w_wr_ste;
  logic [MW-1:0]       w_wr_idx;
  logic [SYMBOL_W-1:0] w_wr_data;
  logic [NUM_STE-1:0]  w_en, w_match, w_next_active, w_rep;

  assign w_xfer   = (r_state == S_RUN) && sym_valid;
  assign w_launch = (r_state == S_IDLE) && start;
  assign w_wr_en  = ((r_state == S_IDLE) && cfg_we && !start) ||
                    ((r_state == S_DONE) && r_pend_v);
  assign w_wr_sel  = (r_state == S_DONE) ? r_pend_sel  : cfg_sel;
  assign w_wr_ste  = (r_state == S_DONE) ? r_pend_ste  : cfg_ste;
  assign w_wr_idx  = (r_state == S_DONE) ? r_pend_idx  : cfg_idx;
  assign w_wr_data = (r_state == S_DONE) ? r_pend_data : cfg_data;

  assign w_en  = r_active | (r_start_f & (~r_mode_f | {NUM_STE{r_first}}));
  assign w_rep = w_match & r_report_f;

  always_comb begin
    w_match       = '0;
    w_next_active = '0;
    for (int i = 0; i < NUM_STE; i++) begin
      for (int k = 0; k < MATCH_PER_STE; k++) begin
        if (r_entry_v[i][k] && (r_entry[i][k] == sym_data)) w_match[i] = w_en[i];
      end
    end
    for (int i = 0; i < NUM_STE; i++) begin
      if (w_match[i]) w_next_active = w_next_active | r_adj[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_xfer && sym_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Entry payloads need no reset: an entry is only consulted while its valid bit is set.
  always_ff @(posedge clock) begin
    if (w_wr_en && (w_wr_sel == 2'd0)) r_entry[w_wr_ste][w_wr_idx] <= w_wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_STE; i++) begin
        r_entry_v[i] <= '0;
        r_adj[i]     <= '0;
      end
      r_start_f      <= '0;
      r_report_f     <= '0;
      r_mode_f       <= '0;
      r_active       <= '0;
      r_first        <= 1'b0;
      r_report_vec   <= '0;
      r_report_valid <= 1'b0;
      r_pend_v       <= 1'b0;
      r_pend_sel     <= '0;
      r_pend_ste     <= '0;
      r_pend_idx     <= '0;
      r_pend_data    <= '0;
    end else begin
      if (w_wr_en) begin
        case (w_wr_sel)
          2'd0: r_entry_v[w_wr_ste][w_wr_idx] <= 1'b1;
          2'd1: r_entry_v[w_wr_ste][w_wr_idx] <= 1'b0;
          2'd2: r_adj[w_wr_ste] <= w_wr_data[NUM_STE-1:0];
          default: begin
            r_start_f[w_wr_ste]  <= w_wr_data[0];
            r_report_f[w_wr_ste] <= w_wr_data[1];
            r_mode_f[w_wr_ste]   <= w_wr_data[2];
          end
        endcase
      end
      if (w_launch && cfg_we) begin
        r_pend_v    <= 1'b1;
        r_pend_sel  <= cfg_sel;
        r_pend_ste  <= cfg_ste;
        r_pend_idx  <= cfg_idx;
        r_pend_data <= cfg_data;
      end else if (r_state == S_DONE) begin
        r_pend_v <= 1'b0;
      end
      if (w_launch) begin
        r_active <= '0;
        r_first  <= 1'b1;
      end else if (w_xfer) begin
        r_active <= w_next_active;
        r_first  <= 1'b0;
      end
      r_report_vec   <= w_xfer ? w_rep : '0;
      r_report_valid <= w_xfer && (|w_rep);
    end
  end

`ifdef STE_REPORT_OFFSET_EN
  logic [31:0] r_sym_cnt, r_report_offset;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sym_cnt       <= '0;
      r_report_offset <= '0;
    end else begin
      if (w_launch)    r_sym_cnt <= '0;
      else if (w_xfer) r_sym_cnt <= r_sym_cnt + 32'd1;
      r_report_offset <= (w_xfer && (|w_rep)) ? r_sym_cnt : '0;
    end
  end
  assign report_offset = r_report_offset;
`endif

  assign sym_ready    = (r_state == S_RUN);
  assign busy         = (r_state == S_RUN);
  assign done         = (r_state == S_DONE);
  assign report_valid = r_report_valid;
  assign report_vec   = r_report_vec;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ste_array_matcher.sv
// Directed and randomized streams for ste_array_matcher, checked against a set-based reference model.
module tb_ste_array_matcher;
  localparam int N = 8;
  localparam int M = 4;
  localparam logic [15:0] AA = "AA", AG = "AG", TA = "TA", TG = "TG", CC = "CC", AT = "AT";

  logic        clock = 1'b0;
  logic        reset, cfg_we, start, sym_valid, sym_last;
  logic [1:0]  cfg_sel;
  logic [2:0]  cfg_ste;
  logic [1:0]  cfg_idx;
  logic [15:0] cfg_data, sym_data;
  logic        sym_ready, busy, done, report_valid;
  logic [7:0]  report_vec;
  logic [1:0]  dbg_state;
`ifdef STE_REPORT_OFFSET_EN
  logic [31:0] report_offset;
`endif

  ste_array_matcher #(.NUM_STE(N), .SYMBOL_W(16), .MATCH_PER_STE(M)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ste(cfg_ste),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .start(start), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .sym_data(sym_data), .sym_last(sym_last), .busy(busy),
    .done(done), .report_valid(report_valid), .report_vec(report_vec),
`ifdef STE_REPORT_OFFSET_EN
    .report_offset(report_offset),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: each STE holds a set of symbols, a set of children and three flags.
  logic [15:0] m_ent [N][M];
  bit          m_v   [N][M];
  logic [7:0]  m_adj [N];
  bit          m_sf [N], m_rf [N], m_md [N];
  logic [15:0] alpha [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < M; k++) m_v[i][k] = 0;
      m_adj[i] = '0;
      m_sf[i] = 0; m_rf[i] = 0; m_md[i] = 0;
    end
  endtask

  task automatic model_write(input int sel, input int ste, input int idx, input logic [15:0] d);
    case (sel)
      0: begin m_ent[ste][idx] = d; m_v[ste][idx] = 1; end
      1: m_v[ste][idx] = 0;
      2: m_adj[ste] = d[7:0];
      default: begin m_sf[ste] = d[0]; m_rf[ste] = d[1]; m_md[ste] = d[2]; end
    endcase
  endtask

  task automatic cfg(input int sel, input int ste, input int idx, input logic [15:0] d);
    cfg_we = 1; cfg_sel = 2'(sel); cfg_ste = 3'(ste); cfg_idx = 2'(idx); cfg_data = d;
    tick();
    cfg_we = 0;
    model_write(sel, ste, idx, d);
  endtask

  // One symbol: which STEs are live, which of them hold the symbol, and where that leads.
  task automatic model_step(input logic [15:0] s, input bit first, inout logic [7:0] act,
                            output logic [7:0] rep);
    logic [7:0] nxt;
    bit live, hit;
    nxt = '0;
    rep = '0;
    for (int i = 0; i < N; i++) begin
      live = act[i] || (m_sf[i] && (!m_md[i] || first));
      hit  = 0;
      for (int k = 0; k < M; k++) if (m_v[i][k] && m_ent[i][k] == s) hit = 1;
      if (live && hit) begin
        nxt = nxt | m_adj[i];
        if (m_rf[i]) rep[i] = 1'b1;
      end
    end
    act = nxt;
  endtask

  task automatic run_stream(input logic [15:0] syms[$], input int gap_at, input int gap_len,
                            input bit rnd_gaps, input bit inj_cfg, input int abort_after,
                            input bit start_cfg);
    logic [7:0] act, rep;
    bit first;
    int g;
    int n;
    n = syms.size();
    start = 1;
    if (start_cfg) begin
      cfg_we = 1; cfg_sel = 2'd1; cfg_ste = 3'd1; cfg_idx = 2'd0; cfg_data = '0;
    end
    tick();
    start = 0; cfg_we = 0;
    chk("busy_run", busy, 1);
    chk("ready_run", sym_ready, 1);
    act = '0;
    first = 1;
    for (int k = 0; k < n; k++) begin
      if (k == abort_after) begin
        reset = 1;
        tick();
        reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rv", report_valid, 0);
        chk("abort_ready", sym_ready, 0);
        model_reset();
        tick();
        chk("post_abort_done", done, 0);
        chk("post_abort_rv", report_valid, 0);
        return;
      end
      g = (k == gap_at) ? gap_len : 0;
      if (rnd_gaps && $urandom_range(0, 3) == 0) g += int'($urandom_range(1, 2));
      if (inj_cfg && k == 1 && g == 0) g = 1;
      for (int c = 0; c < g; c++) begin
        if (inj_cfg && k == 1 && c == 0) begin
          cfg_we = 1; cfg_sel = 2'd1; cfg_ste = 3'd1; cfg_idx = 2'd0;
        end
        start = rnd_gaps;
        tick();
        cfg_we = 0; start = 0;
        chk("gap_rv", report_valid, 0);
        chk("gap_vec", report_vec, 0);
        chk("gap_done", done, 0);
        chk("gap_busy", busy, 1);
      end
      sym_valid = 1; sym_data = syms[k]; sym_last = (k == n - 1);
      tick();
      sym_valid = 0; sym_last = 0;
      model_step(syms[k], first, act, rep);
      first = 0;
      chk("rep_vec", report_vec, rep);
      chk("rep_valid", report_valid, |rep);
      chk("done", done, k == n - 1);
`ifdef STE_REPORT_OFFSET_EN
      if (|rep) chk("offset", report_offset, k);
`endif
    end
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_rv", report_valid, 0);
    chk("idle_state", dbg_state, 0);
    if (start_cfg) model_write(1, 1, 0, '0);
  endtask

  task automatic program_base();
    cfg(0, 0, 0, AA); cfg(0, 0, 1, AG); cfg(0, 0, 2, TA); cfg(0, 0, 3, TG);
    cfg(3, 0, 0, 16'h1);
    cfg(0, 1, 0, CC);
    cfg(3, 1, 0, 16'h2);
    cfg(2, 0, 0, 16'h2);
    cfg(2, 1, 0, 16'h2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] q[$];
    alpha[0] = AA; alpha[1] = AG; alpha[2] = CC; alpha[3] = TA;
    reset = 1; cfg_we = 0; cfg_sel = '0; cfg_ste = '0; cfg_idx = '0; cfg_data = '0;
    start = 0; sym_valid = 0; sym_data = '0; sym_last = 0;
    model_reset();
    tick(); tick();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rv", report_valid, 0);
    chk("rst_vec", report_vec, 0);
    chk("rst_ready", sym_ready, 0);
    chk("rst_state", dbg_state, 0);

    program_base();
    q = '{AA, AG, CC, CC, AT, CC};
    run_stream(q, -1, 0, 0, 0, -1, 0);

    cfg(3, 0, 0, 16'h5);
    q = '{AG, TA, CC};
    run_stream(q, -1, 0, 0, 0, -1, 0);
    q = '{AA, CC};
    run_stream(q, -1, 0, 0, 0, -1, 0);

    cfg(3, 0, 0, 16'h1);
    q = '{AA, CC, CC};
    run_stream(q, 1, 3, 0, 0, -1, 0);
    run_stream(q, -1, 0, 0, 1, -1, 0);
    cfg(1, 1, 0, '0);
    q = '{AA, CC};
    run_stream(q, -1, 0, 0, 0, -1, 0);

    cfg(0, 1, 0, CC);
    run_stream(q, -1, 0, 0, 0, -1, 1);
    run_stream(q, -1, 0, 0, 0, -1, 0);

    cfg(0, 1, 0, CC);
    q = '{AA, CC, CC, CC, AT, CC};
    run_stream(q, -1, 0, 0, 0, 2, 0);
    q = '{AA, CC};
    run_stream(q, -1, 0, 0, 0, -1, 0);
    program_base();
    q = '{AA, AG, CC, CC, AT, CC};
    run_stream(q, -1, 0, 0, 0, -1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < M; k++) begin
          if ($urandom_range(0, 1) == 1) cfg(0, i, k, alpha[$urandom_range(0, 3)]);
          else cfg(1, i, k, '0);
        end
        cfg(2, i, 0, 16'($urandom_range(0, 255)));
        cfg(3, i, 0, 16'($urandom_range(0, 7)));
      end
      for (int s = 0; s < 4; s++) begin
        q = {};
        for (int k = 0; k < int'($urandom_range(1, 8)); k++) q.push_back(alpha[$urandom_range(0, 3)]);
        run_stream(q, -1, 0, 1, 0, -1, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
